// File: rtl/vblank_update_scheduler_pkg.sv
// rtl/vblank_update_scheduler_pkg.sv - VGA timing constants and scheduler FSM state encoding
package vblank_update_scheduler_pkg;

    localparam int H_VISIBLE     = 640;
    localparam int H_FRONT_PORCH = 16;
    localparam int H_SYNC        = 96;
    localparam int H_BACK_PORCH  = 48;
    localparam int H_TOTAL       = H_VISIBLE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;

    localparam int V_VISIBLE     = 480;
    localparam int V_FRONT_PORCH = 10;
    localparam int V_SYNC        = 2;
    localparam int V_BACK_PORCH  = 29;
    localparam int V_TOTAL       = V_VISIBLE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;

    localparam logic [9:0] VGA_VBLANK_START = 10'd480;
    localparam logic [9:0] VGA_LAST_GRANT   = 10'd515;
    localparam logic [9:0] VGA_V_LAST       = 10'd520;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_GRANT = 2'd2
    } sched_state_t;

endpackage

// File: rtl/vblank_update_scheduler_rr_arbiter.sv
// rtl/vblank_update_scheduler_rr_arbiter.sv - combinational round-robin pick of the first eligible bit at or after the pointer
module vblank_update_scheduler_rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_eligible,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    int w_idx;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!o_valid && i_eligible[w_idx]) begin
                o_onehot[w_idx] = 1'b1;
                o_idx           = PTR_W'(w_idx);
                o_valid         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vblank_update_scheduler.sv
// rtl/vblank_update_scheduler.sv - vblank update-slot scheduler with frame tick and frame counter
// Optional OVERRUN_STATS_EN adds a saturating overrun counter output.
module vblank_update_scheduler
    import vblank_update_scheduler_pkg::*;
#(
    parameter int         N_REQ        = 3,
    parameter logic [9:0] VBLANK_START = VGA_VBLANK_START,
    parameter logic [9:0] LAST_GRANT   = VGA_LAST_GRANT,
    parameter logic [9:0] V_LAST       = VGA_V_LAST
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [9:0]       i_y,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_done,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_window_open,
    output logic             o_frame_tick,
    output logic             o_overrun,
`ifdef OVERRUN_STATS_EN
    output logic [15:0]      o_frame_cnt,
    output logic [7:0]       o_overrun_cnt
`else
    output logic [15:0]      o_frame_cnt
`endif
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    sched_state_t     r_state;
    logic [9:0]       r_y_q;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] r_served;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_gidx;
    logic             r_closed;
    logic             r_window_open;
    logic             r_frame_tick;
    logic             r_overrun;
    logic [15:0]      r_frame_cnt;

    logic             w_in_window;
    logic             w_tick;
    logic             w_close;
    logic             w_done;
    logic             w_overrun_set;
    logic [N_REQ-1:0] w_eligible;
    logic [N_REQ-1:0] w_arb_onehot;
    logic [PTR_W-1:0] w_arb_idx;
    logic             w_arb_valid;
    logic [PTR_W-1:0] w_ptr_next;

    assign w_in_window   = (i_y >= VBLANK_START) && (i_y <= V_LAST);
    assign w_tick        = (i_y == VBLANK_START) && (r_y_q != VBLANK_START);
    // r_window_open holds the window state of the previous y sample
    assign w_close       = r_window_open && !w_in_window;
    assign w_done        = |(i_done & r_grant);
    assign w_overrun_set = (r_state == ST_GRANT) && w_close && !w_done;
    assign w_eligible    = i_req & ~r_served;
    assign w_ptr_next    = (r_gidx == PTR_W'(N_REQ - 1)) ? '0 : r_gidx + PTR_W'(1);

    vblank_update_scheduler_rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_onehot   (w_arb_onehot),
        .o_idx      (w_arb_idx),
        .o_valid    (w_arb_valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_y_q         <= '0;
            r_grant       <= '0;
            r_served      <= '0;
            r_ptr         <= '0;
            r_gidx        <= '0;
            r_closed      <= 1'b0;
            r_window_open <= 1'b0;
            r_frame_tick  <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_y_q         <= i_y;
            r_window_open <= w_in_window;
            r_frame_tick  <= w_tick;
            r_overrun     <= w_overrun_set;
            if (w_tick) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (!w_in_window || (i_y > LAST_GRANT)) begin
                        r_state <= ST_IDLE;
                    end else if (w_arb_valid) begin
                        r_grant  <= w_arb_onehot;
                        r_gidx   <= w_arb_idx;
                        r_closed <= 1'b0;
                        r_state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_done) begin
                        r_grant         <= '0;
                        r_served[r_gidx] <= 1'b1;
                        r_ptr           <= w_ptr_next;
                        // a new frame tick reopens arbitration even after an overrun
                        r_state         <= ((r_closed && !w_tick) || w_close) ? ST_IDLE : ST_ARB;
                    end else if (w_close) begin
                        r_closed <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_tick) begin
                r_served <= '0;
                r_closed <= 1'b0;
            end
        end
    end

`ifdef OVERRUN_STATS_EN
    logic [7:0] r_overrun_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overrun_cnt <= '0;
        end else if (w_overrun_set && (r_overrun_cnt != 8'hFF)) begin
            r_overrun_cnt <= r_overrun_cnt + 8'd1;
        end
    end

    assign o_overrun_cnt = r_overrun_cnt;
`endif

    assign o_grant       = r_grant;
    assign o_window_open = r_window_open;
    assign o_frame_tick  = r_frame_tick;
    assign o_overrun     = r_overrun;
    assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// tb/tb_vblank_update_scheduler.sv - scoreboard bench for vblank_update_scheduler
module tb_vblank_update_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  y;
    logic [2:0]  req;
    logic [2:0]  done;
    logic [2:0]  grant;
    logic        window_open;
    logic        frame_tick;
    logic        overrun;
    logic [15:0] frame_cnt;
`ifdef OVERRUN_STATS_EN
    logic [7:0]  overrun_cnt;
`endif

    logic [2:0]  auto_done = '0;
    logic [2:0]  man_done  = '0;
    logic        auto_en   = 1'b0;
    assign done = auto_done | man_done;

    int total = 0;
    int bad   = 0;

    logic [2:0]  q_grant[$];
    logic [15:0] q_tick[$];
    logic [2:0]  q_ovr[$];

    always #5 clk = ~clk;

    vblank_update_scheduler dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_y           (y),
        .i_req         (req),
        .i_done        (done),
        .o_grant       (grant),
        .o_window_open (window_open),
        .o_frame_tick  (frame_tick),
        .o_overrun     (overrun),
`ifdef OVERRUN_STATS_EN
        .o_frame_cnt   (frame_cnt),
        .o_overrun_cnt (overrun_cnt)
`else
        .o_frame_cnt   (frame_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        y = (y == 10'd520) ? 10'd0 : y + 10'd1;
    endtask

    task automatic goto(input logic [9:0] target);
        int n = 0;
        while (y != target && n < 600) begin
            step();
            n++;
        end
        if (y != target) chk("goto_timeout", {22'd0, y}, {22'd0, target});
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event
    initial begin
        logic [2:0] prev_grant = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (grant != 3'b000 && grant != prev_grant) begin
                    if (q_grant.size() > 0) chk("grant_order", {29'd0, grant}, {29'd0, q_grant.pop_front()});
                    else chk("grant_unexpected", {29'd0, grant}, 32'd0);
                end
                if (frame_tick) begin
                    if (q_tick.size() > 0) chk("tick_frame_cnt", {16'd0, frame_cnt}, {16'd0, q_tick.pop_front()});
                    else chk("tick_unexpected", {31'd0, frame_tick}, 32'd0);
                end
                if (overrun) begin
                    if (q_ovr.size() > 0) chk("overrun_held_grant", {29'd0, grant}, {29'd0, q_ovr.pop_front()});
                    else chk("overrun_unexpected", {31'd0, overrun}, 32'd0);
                end
            end
            prev_grant = grant;
        end
    end

    // Auto responder: pulses done five cycles after a grant appears
    initial begin
        int gcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!auto_en) begin
                auto_done = '0;
                gcnt = 0;
            end else if (grant != 3'b000 && auto_done == 3'b000) begin
                gcnt++;
                if (gcnt >= 5) begin
                    auto_done = grant;
                    gcnt = 0;
                end
            end else begin
                auto_done = '0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        y   = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_grant", {29'd0, grant}, 32'd0);
        chk("rst_window", {31'd0, window_open}, 32'd0);
        chk("rst_tick", {31'd0, frame_tick}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);

        // 1: idle sweep, one tick, window tracks y
        q_tick.push_back(16'd1);
        goto(10'd480);
        chk("window_before", {31'd0, window_open}, 32'd0);
        step();
        chk("window_in", {31'd0, window_open}, 32'd1);
        goto(10'd520);
        step();
        goto(10'd1);
        chk("window_after_wrap", {31'd0, window_open}, 32'd0);
        chk("frame_cnt_1", {16'd0, frame_cnt}, 32'd1);

        // 2: all three requesters in order, once each
        auto_en = 1'b1;
        req = 3'b111;
        q_grant.push_back(3'b001);
        q_grant.push_back(3'b010);
        q_grant.push_back(3'b100);
        q_tick.push_back(16'd2);
        goto(10'd520);
        step();

        // 3: pointer left after 010, then 101 serves 100 first
        req = 3'b010;
        q_grant.push_back(3'b010);
        q_tick.push_back(16'd3);
        goto(10'd520);
        step();
        req = 3'b101;
        q_grant.push_back(3'b100);
        q_grant.push_back(3'b001);
        q_tick.push_back(16'd4);
        goto(10'd520);
        step();
        req = 3'b000;

        // 4: late grant, done withheld past the wrap
        auto_en = 1'b0;
        q_tick.push_back(16'd5);
        goto(10'd513);
        req = 3'b001;
        q_grant.push_back(3'b001);
        q_ovr.push_back(3'b001);
        goto(10'd1);
        chk("grant_held_after_wrap", {29'd0, grant}, 32'd1);
        goto(10'd2);
        man_done = 3'b001;
        step();
        man_done = 3'b000;
        chk("grant_released", {29'd0, grant}, 32'd0);
        req = 3'b000;
`ifdef OVERRUN_STATS_EN
        chk("overrun_cnt", {24'd0, overrun_cnt}, 32'd1);
`endif

        // 5: request after the last grant line waits for the next frame
        q_tick.push_back(16'd6);
        goto(10'd516);
        req = 3'b010;
        goto(10'd520);
        step();
        q_tick.push_back(16'd7);
        q_grant.push_back(3'b010);
        goto(10'd480);
        chk("no_grant_before_window", {29'd0, grant}, 32'd0);
        goto(10'd484);
        chk("late_req_granted", {29'd0, grant}, 32'd2);

        // 6: reset mid-grant, then spurious done ignored
        req = 3'b001;
        rst = 1'b1;
        step();
        chk("rst_mid_grant", {29'd0, grant}, 32'd0);
        chk("rst_mid_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        rst = 1'b0;
        goto(10'd520);
        step();
        q_tick.push_back(16'd1);
        q_grant.push_back(3'b001);
        goto(10'd490);
        man_done = 3'b010;
        step();
        man_done = 3'b000;
        chk("spurious_done_ignored", {29'd0, grant}, 32'd1);
        man_done = 3'b001;
        step();
        man_done = 3'b000;
        chk("done_releases", {29'd0, grant}, 32'd0);
        req = 3'b000;
        repeat (5) step();

        chk("grant_queue_empty", q_grant.size(), 32'd0);
        chk("tick_queue_empty", q_tick.size(), 32'd0);
        chk("overrun_queue_empty", q_ovr.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
